// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional write-first bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  // Index width, never narrower than one bit.
  function automatic int calc_addr_w(input int depth);
    int w;
    w = $clog2(depth);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Access bus of the multi-port register file: one write port, NUM_RD read ports, clear control.
// Optional write-first bypass (REGFILE_BYPASS_EN) does not change this bus.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = calc_addr_w(DEF_DEPTH),
  parameter int NUM_RD = DEF_NUM_RD
);

  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic [NUM_RD-1:0]              rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
  logic [NUM_RD-1:0]              rd_valid;
  logic                           clr_req;
  logic                           busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output rd_data, rd_valid, busy
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port; holds the zero-register override and, with
// REGFILE_BYPASS_EN defined, the write-first bypass mux.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              busy,
  input  logic [DATA_W-1:0] mem_data,
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_commit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic              zero_hit_s;
  logic [DATA_W-1:0] rd_next_s;

  // Select the value to capture; zero register wins over any bypass.
  always_comb begin
    zero_hit_s = (ZERO_REG != 0) && (rd_addr == {ADDR_W{1'b0}});
    if (zero_hit_s) begin
      rd_next_s = {DATA_W{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (wr_commit && (wr_addr == rd_addr)) begin
      rd_next_s = wr_data;
    end
`endif
    else begin
      rd_next_s = mem_data;
    end
  end

  // Output registers: data holds when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= {DATA_W{1'b0}};
      rd_valid <= 1'b0;
    end else if (rd_en && !busy) begin
      rd_data  <= rd_next_s;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing sweep after reset or on request.
// Define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int                ADDR_W   = calc_addr_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state_r;
  clr_state_e        state_next_s;
  logic [ADDR_W-1:0] clr_idx_r;
  logic [ADDR_W-1:0] clr_idx_next_s;
  logic              busy_s;
  logic              clr_we_s;
  logic              wr_commit_s;

  logic [DATA_W-1:0] mem_r      [DEPTH];
  logic [DATA_W-1:0] rd_word_s  [NUM_RD];
  logic [DATA_W-1:0] rd_data_s  [NUM_RD];
  logic              rd_valid_s [NUM_RD];

  // Clear FSM state register; reset lands in CLEAR so the array is swept first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= CLEAR;
      clr_idx_r <= {ADDR_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      clr_idx_r <= clr_idx_next_s;
    end
  end

  // Clear FSM next state; clr_req is only honoured from IDLE.
  always_comb begin
    state_next_s   = state_r;
    clr_idx_next_s = clr_idx_r;
    case (state_r)
      IDLE: begin
        clr_idx_next_s = {ADDR_W{1'b0}};
        if (bus.clr_req) begin
          state_next_s = CLEAR;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_idx_r == LAST_IDX) begin
          state_next_s   = IDLE;
          clr_idx_next_s = {ADDR_W{1'b0}};
        end else begin
          state_next_s   = CLEAR;
          clr_idx_next_s = clr_idx_r + ADDR_W'(1);
        end
      end
      default: begin
        state_next_s   = CLEAR;
        clr_idx_next_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Clear FSM outputs.
  always_comb begin
    case (state_r)
      IDLE: begin
        busy_s   = 1'b0;
        clr_we_s = 1'b0;
      end
      CLEAR: begin
        busy_s   = 1'b1;
        clr_we_s = 1'b1;
      end
      default: begin
        busy_s   = 1'b1;
        clr_we_s = 1'b0;
      end
    endcase
  end

  // A write commits only when idle, in range, and not aimed at a hardwired zero register.
  always_comb begin
    wr_commit_s = 1'b0;
    if (bus.wr_en && !busy_s && ({1'b0, bus.wr_addr} < DEPTH_L)) begin
      if ((ZERO_REG != 0) && (bus.wr_addr == {ADDR_W{1'b0}})) begin
        wr_commit_s = 1'b0;
      end else begin
        wr_commit_s = 1'b1;
      end
    end else begin
      wr_commit_s = 1'b0;
    end
  end

  // Storage array, deliberately without reset; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_idx_r] <= {DATA_W{1'b0}};
    end else if (wr_commit_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Array read per port; out-of-range indices read as zero.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      if ({1'b0, bus.rd_addr[p]} < DEPTH_L) begin
        rd_word_s[p] = mem_r[bus.rd_addr[p]];
      end else begin
        rd_word_s[p] = {DATA_W{1'b0}};
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (bus.rd_en[p]),
      .rd_addr   (bus.rd_addr[p]),
      .busy      (busy_s),
      .mem_data  (rd_word_s[p]),
`ifdef REGFILE_BYPASS_EN
      .wr_commit (wr_commit_s),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
`endif
      .rd_data   (rd_data_s[p]),
      .rd_valid  (rd_valid_s[p])
    );
  end

  // Drive the bus outputs from the per-port registers and FSM decode.
  always_comb begin
    bus.busy = busy_s;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p]  = rd_data_s[p];
      bus.rd_valid[p] = rd_valid_s[p];
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..256, not necessarily a power of 2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit: write request this cycle.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: write index, where ADDR_W = max(1, clog2(DEPTH)).
REQ-009 SHALL have port wr_data, input, DATA_W bits: write value.
REQ-010 SHALL have port rd_en, input, NUM_RD bits: per-port read request.
REQ-011 SHALL have port rd_addr, input, NUM_RD x ADDR_W bits: per-port read index.
REQ-012 SHALL have port rd_data, output, NUM_RD x DATA_W bits: per-port registered read result.
REQ-013 SHALL have port rd_valid, output, NUM_RD bits: per-port pulse qualifying rd_data.
REQ-014 SHALL have port clr_req, input, 1 bit: request a full array clear.
REQ-015 SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-016 SHALL give each read port 1-cycle latency: rd_en[p] high in cycle N yields rd_data[p] and rd_valid[p]=1 in N+1.
REQ-017 SHALL hold rd_data[p] unchanged and drive rd_valid[p]=0 in the cycle after rd_en[p] is low.
REQ-018 SHALL let all read ports read any address concurrently, including the same address.
REQ-019 SHALL commit wr_data to wr_addr at the clock edge when wr_en=1 and busy=0.
REQ-020 SHALL ignore writes to wr_addr >= DEPTH; reads of addresses >= DEPTH SHALL return 0 with rd_valid=1.
REQ-021 With ZERO_REG=1, SHALL drop writes to address 0, and reads of address 0 SHALL return 0.
REQ-022 SHALL implement clear FSM states IDLE and CLEAR: IDLE to CLEAR on clr_req=1; CLEAR writes 0 to one register per cycle at index clr_idx, from 0 up to DEPTH-1; after index DEPTH-1, return to IDLE.
REQ-023 SHALL assert busy exactly while in CLEAR, so a sweep lasts DEPTH cycles.
REQ-024 While busy=1, SHALL ignore wr_en, and SHALL ignore rd_en with rd_valid=0; clr_req in CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-025 When clr_req and wr_en are both high in IDLE, the write SHALL commit and the sweep SHALL begin the next cycle, so the write is overwritten.

Reset
REQ-026 Asserting rst SHALL asynchronously force rd_data=0, rd_valid=0, clr_idx=0, and state=CLEAR.
REQ-027 After rst deasserts, the block SHALL perform a full clear sweep, with busy=1 for DEPTH cycles, before accepting accesses.
REQ-028 The storage array SHALL NOT be directly reset; it is zeroed only by the sweep.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from index 0.

Configuration
REQ-030 When REGFILE_BYPASS_EN is defined, a read in the same cycle as a committing write to the same valid address SHALL return wr_data (write-first).
REQ-031 Without REGFILE_BYPASS_EN, that read SHALL return the pre-write value (read-first).
REQ-032 The ZERO_REG and out-of-range rules SHALL take precedence over bypass in both builds.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, CLEAR) and default width constants in package regfile_pkg.
REQ-034 SHALL implement the read path as one sub-module, regfile_rd_port, instantiated NUM_RD times; it holds the bypass mux and output registers.

Verification
REQ-035 Reset scenario: rst pulse, then idle. Required response: busy=1 for exactly 32 cycles, then 0; every read of addresses 0..31 returns 0x0.
REQ-036 Write/read scenario: write 0xDEADBEEF to address 5 in cycle N, read port 0 address 5 in N+1. Required response: rd_data[0]=0xDEADBEEF and rd_valid[0]=1 in N+2.
REQ-037 Same-cycle collision scenario: write 0x1234 to address 7 while port 1 reads address 7 (old value 0xA). Required response: rd_data[1]=0x1234 with REGFILE_BYPASS_EN defined; 0xA without it.
REQ-038 Zero-register scenario: with ZERO_REG=1, write 0xFFFFFFFF to address 0, then read it on both ports. Required response: 0x0 on both ports.
REQ-039 Mid-operation clear scenario: fill address 3 with 0x55, assert clr_req, issue a write and reads at cycle 10 of the sweep. Required response: rd_valid=0 and the write is dropped; after busy falls, address 3 reads 0x0.
REQ-040 Reset-mid-sweep scenario: assert rst at sweep index 20. Required response: busy stays high for 32 cycles after rst deasserts.
